mem_access_ctrl: RTL and testbench

//  Arbitrates the CPU's single MMU port between instruction fetch (IF) and load/store (MEM).

---
 rtl/mem_access_ctrl_if.sv | 25 ++
 rtl/mem_access_ctrl.sv | 91 +++++++++
 tb/tb_mem_access_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU fetch/data request ports and MMU port bundled for mem_access_ctrl
interface mem_access_ctrl_if;
  logic        if_req, if_flush, if_ready, if_err, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_signed, d_ready, d_err, d_stall;
  logic [1:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_ready;
  logic [1:0]  mmu_mem_data_width;
  logic [31:0] mmu_address, mmu_data_in, mmu_data_out;
  modport slave (
    input  if_req, if_addr, if_flush, d_req, d_we, d_signed, d_width, d_addr, d_wdata,
           mmu_mem_ready, mmu_data_out,
    output if_ready, if_rdata, if_err, if_stall, d_ready, d_rdata, d_err, d_stall,
           mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_data_width,
           mmu_address, mmu_data_in
  );
  modport master (
    output if_req, if_addr, if_flush, d_req, d_we, d_signed, d_width, d_addr, d_wdata,
           mmu_mem_ready, mmu_data_out,
    input  if_ready, if_rdata, if_err, if_stall, d_ready, d_rdata, d_err, d_stall,
           mmu_read_enable, mmu_write_enable, mmu_mem_signed_read, mmu_mem_data_width,
           mmu_address, mmu_data_in
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates the single MMU port between instruction fetch and load/store
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_D_STREAK   = 4
) (
  input logic clk,
  input logic reset,
  mem_access_ctrl_if.slave bus
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t state, state_n;
  logic [31:0] lat_addr, lat_wdata;
  logic [1:0]  lat_width;
  logic        lat_we, lat_signed, drop;
  logic [TW-1:0] tmo_cnt;
  logic [SW-1:0] streak;
  logic f_elig, d_elig, grant_d, grant_f, busy, done, tmo;
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // grant arbitration, completion/timeout detection and next state
  always_comb begin
    f_elig  = bus.if_req && !bus.if_ready && !bus.if_flush;
    d_elig  = bus.d_req && !bus.d_ready;
    grant_d = state == IDLE && d_elig && !(streak == SW'(MAX_D_STREAK) && f_elig);
    grant_f = state == IDLE && f_elig && !grant_d;
    busy    = state != IDLE;
    done    = busy && bus.mmu_mem_ready;
    tmo     = busy && !bus.mmu_mem_ready && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
    state_n = grant_d ? DATA : grant_f ? FETCH : (done || tmo) ? IDLE : state;
  end
  assign bus.mmu_read_enable     = busy && !lat_we;
  assign bus.mmu_write_enable    = busy && lat_we;
  assign bus.mmu_mem_signed_read = lat_signed;
  assign bus.mmu_mem_data_width  = lat_width;
  assign bus.mmu_address         = lat_addr;
  assign bus.mmu_data_in         = lat_wdata;
  assign bus.if_stall            = bus.if_req && !bus.if_ready;
  assign bus.d_stall             = bus.d_req && !bus.d_ready;
  // access latches, counters, drop flag and per-port response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_addr <= '0;
      lat_wdata <= '0;
      lat_width <= '0;
      lat_we <= 1'b0;
      lat_signed <= 1'b0;
      drop <= 1'b0;
      tmo_cnt <= '0;
      streak <= '0;
      bus.if_ready <= 1'b0;
      bus.if_err <= 1'b0;
      bus.if_rdata <= '0;
      bus.d_ready <= 1'b0;
      bus.d_err <= 1'b0;
      bus.d_rdata <= '0;
    end else begin
      bus.if_ready <= 1'b0;
      bus.if_err <= 1'b0;
      bus.d_ready <= 1'b0;
      bus.d_err <= 1'b0;
      if (grant_d || grant_f) begin
        lat_addr <= grant_d ? bus.d_addr : bus.if_addr;
        lat_wdata <= grant_d ? bus.d_wdata : lat_wdata;
        lat_width <= grant_d ? bus.d_width : 2'b10;
        lat_we <= grant_d && bus.d_we;
        lat_signed <= grant_d && bus.d_signed;
        tmo_cnt <= '0;
        streak <= grant_d && f_elig ? streak + 1'b1 : '0;
      end
      if (busy) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == FETCH) drop <= drop || bus.if_flush;
      if (done || tmo) begin
        drop <= 1'b0;
        if (state == DATA) begin
          bus.d_ready <= 1'b1;
          bus.d_err <= tmo;
          bus.d_rdata <= (tmo || lat_we) ? '0 : bus.mmu_data_out;
        end else if (!drop && !bus.if_flush) begin
          bus.if_ready <= 1'b1;
          bus.if_err <= tmo;
          bus.if_rdata <= tmo ? '0 : bus.mmu_data_out;
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl with a simple MMU model
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int mmu_lat = 1;
  bit mmu_off = 1'b0;
  int sc = 0;
  mem_access_ctrl_if bus();
  mem_access_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a == 32'h40 ? 32'h0000_0013 : a ^ 32'hA5A5_0000;
  endfunction
  // MMU model: ready after mmu_lat strobe cycles, stores return junk data
  always @(negedge clk) begin
    if (bus.mmu_read_enable || bus.mmu_write_enable) begin
      bus.mmu_mem_ready = !mmu_off && sc == mmu_lat;
      bus.mmu_data_out = !bus.mmu_mem_ready ? 32'h0 : bus.mmu_write_enable ? 32'hDEAD_BEEF : mem_word(bus.mmu_address);
      sc = bus.mmu_mem_ready ? 0 : sc + 1;
    end else begin
      bus.mmu_mem_ready = 1'b0;
      sc = 0;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input bit d, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      tick;
      if (d ? bus.d_ready : bus.if_ready) begin
        n = i;
        break;
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    checks++; if ({bus.if_ready, bus.if_err, bus.d_ready, bus.d_err} !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", {bus.if_ready, bus.if_err, bus.d_ready, bus.d_err}); end
    checks++; if ({bus.mmu_read_enable, bus.mmu_write_enable} !== 2'b0) begin errors++; $display("FAIL reset_enables got %b want 00", {bus.mmu_read_enable, bus.mmu_write_enable}); end
    checks++; if (bus.mmu_address !== 32'h0 || bus.if_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL reset_data addr %h if_rdata %h d_rdata %h want 0", bus.mmu_address, bus.if_rdata, bus.d_rdata); end
    reset = 1'b0;
    tick;
  endtask
  task automatic test_fetch;
    int n;
    mmu_lat = 2;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    tick;
    checks++; if (!bus.mmu_read_enable || bus.mmu_address !== 32'h40 || bus.mmu_mem_data_width !== 2'b10 || bus.mmu_write_enable) begin errors++; $display("FAIL fetch_strobe re %b we %b addr %h w %b", bus.mmu_read_enable, bus.mmu_write_enable, bus.mmu_address, bus.mmu_mem_data_width); end
    checks++; if (bus.if_stall !== 1'b1) begin errors++; $display("FAIL fetch_stall got %b want 1", bus.if_stall); end
    wait_ready(1'b0, 20, n);
    checks++; if (n + 1 !== 4) begin errors++; $display("FAIL fetch_latency got %0d want 4", n + 1); end
    checks++; if (bus.if_rdata !== 32'h13 || bus.if_err !== 1'b0 || bus.if_stall !== 1'b0) begin errors++; $display("FAIL fetch_data rdata %h err %b stall %b want 00000013 0 0", bus.if_rdata, bus.if_err, bus.if_stall); end
    bus.if_req = 1'b0;
    tick;
    checks++; if (bus.if_ready !== 1'b0 || bus.if_rdata !== 32'h13 || bus.mmu_read_enable !== 1'b0 || bus.mmu_address !== 32'h40) begin errors++; $display("FAIL fetch_after ready %b rdata %h re %b addr %h", bus.if_ready, bus.if_rdata, bus.mmu_read_enable, bus.mmu_address); end
  endtask
  task automatic test_priority;
    int n;
    mmu_lat = 0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h80;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_width = 2'b10;
    bus.d_addr = 32'h100;
    tick;
    checks++; if (!bus.mmu_read_enable || bus.mmu_address !== 32'h100) begin errors++; $display("FAIL prio_data_first re %b addr %h want 1 00000100", bus.mmu_read_enable, bus.mmu_address); end
    wait_ready(1'b1, 10, n);
    checks++; if (n !== 1) begin errors++; $display("FAIL prio_d_latency got %0d want 1", n); end
    checks++; if (bus.d_rdata !== 32'hA5A5_0100 || bus.if_stall !== 1'b1) begin errors++; $display("FAIL prio_d_data rdata %h stall %b want a5a50100 1", bus.d_rdata, bus.if_stall); end
    bus.d_req = 1'b0;
    tick;
    checks++; if (!bus.mmu_read_enable || bus.mmu_address !== 32'h80 || bus.if_stall !== 1'b1) begin errors++; $display("FAIL prio_fetch_next re %b addr %h stall %b", bus.mmu_read_enable, bus.mmu_address, bus.if_stall); end
    wait_ready(1'b0, 10, n);
    checks++; if (n !== 1 || bus.if_rdata !== 32'hA5A5_0080) begin errors++; $display("FAIL prio_fetch n %0d rdata %h want 1 a5a50080", n, bus.if_rdata); end
    bus.if_req = 1'b0;
    tick;
  endtask
  task automatic test_streak;
    int n, dc;
    bit found;
    mmu_lat = 0;
    dc = 0;
    found = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h44;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h300;
    repeat (60) begin
      tick;
      bus.if_flush = bus.d_ready;
      if (bus.d_ready) dc++;
      if (bus.mmu_read_enable && bus.mmu_address == 32'h44) begin
        found = 1'b1;
        break;
      end
    end
    bus.if_flush = 1'b0;
    checks++; if (!found || dc !== 4) begin errors++; $display("FAIL streak_count found %b data_grants %0d want 1 4", found, dc); end
    wait_ready(1'b0, 10, n);
    checks++; if (n !== 1 || bus.if_rdata !== 32'hA5A5_0044) begin errors++; $display("FAIL streak_fetch n %0d rdata %h want 1 a5a50044", n, bus.if_rdata); end
    bus.if_req = 1'b0;
    repeat (2) begin
      wait_ready(1'b1, 10, n);
      checks++; if (n < 1 || bus.d_rdata !== 32'hA5A5_0300) begin errors++; $display("FAIL streak_tail n %0d rdata %h want a5a50300", n, bus.d_rdata); end
    end
    bus.d_req = 1'b0;
    tick;
  endtask
  task automatic test_store;
    int n;
    mmu_lat = 1;
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_signed = 1'b0;
    bus.d_width = 2'b00;
    bus.d_addr = 32'h203;
    bus.d_wdata = 32'hAB;
    tick;
    checks++; if (!bus.mmu_write_enable || bus.mmu_read_enable || bus.mmu_address !== 32'h203 || bus.mmu_data_in !== 32'hAB || bus.mmu_mem_data_width !== 2'b00) begin errors++; $display("FAIL store_strobe we %b re %b addr %h din %h w %b", bus.mmu_write_enable, bus.mmu_read_enable, bus.mmu_address, bus.mmu_data_in, bus.mmu_mem_data_width); end
    wait_ready(1'b1, 10, n);
    checks++; if (n !== 2 || bus.d_rdata !== 32'h0 || bus.d_err !== 1'b0) begin errors++; $display("FAIL store_done n %0d rdata %h err %b want 2 0 0", n, bus.d_rdata, bus.d_err); end
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    tick;
  endtask
  task automatic test_timeout;
    int n;
    mmu_off = 1'b1;
    bus.d_req = 1'b1;
    bus.d_signed = 1'b1;
    bus.d_width = 2'b01;
    bus.d_addr = 32'h400;
    tick;
    checks++; if (!bus.mmu_read_enable || bus.mmu_mem_signed_read !== 1'b1 || bus.mmu_mem_data_width !== 2'b01) begin errors++; $display("FAIL tmo_strobe re %b signed %b w %b want 1 1 01", bus.mmu_read_enable, bus.mmu_mem_signed_read, bus.mmu_mem_data_width); end
    wait_ready(1'b1, 100, n);
    checks++; if (n !== 64 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin errors++; $display("FAIL tmo_abort n %0d err %b rdata %h want 64 1 0", n, bus.d_err, bus.d_rdata); end
    bus.d_req = 1'b0;
    mmu_off = 1'b0;
    mmu_lat = 0;
    tick;
    bus.d_req = 1'b1;
    bus.d_signed = 1'b0;
    bus.d_addr = 32'h404;
    tick;
    checks++; if (!bus.mmu_read_enable || bus.mmu_address !== 32'h404) begin errors++; $display("FAIL tmo_next_grant re %b addr %h want 1 00000404", bus.mmu_read_enable, bus.mmu_address); end
    wait_ready(1'b1, 10, n);
    checks++; if (n !== 1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'hA5A5_0404) begin errors++; $display("FAIL tmo_next_done n %0d err %b rdata %h", n, bus.d_err, bus.d_rdata); end
    bus.d_req = 1'b0;
    tick;
  endtask
  task automatic test_flush;
    bit seen;
    mmu_lat = 3;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h48;
    tick;
    tick;
    bus.if_flush = 1'b1;
    tick;
    bus.if_flush = 1'b0;
    bus.if_req = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick;
      if (bus.if_ready) seen = 1'b1;
    end
    checks++; if (seen || bus.mmu_read_enable || bus.if_rdata !== 32'hA5A5_0044) begin errors++; $display("FAIL flush_mid ready_seen %b re %b rdata %h want 0 0 a5a50044", seen, bus.mmu_read_enable, bus.if_rdata); end
    mmu_lat = 1;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4C;
    tick;
    tick;
    bus.if_flush = 1'b1;
    bus.if_req = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick;
      bus.if_flush = 1'b0;
      if (bus.if_ready) seen = 1'b1;
    end
    checks++; if (seen || bus.mmu_read_enable || bus.if_rdata !== 32'hA5A5_0044) begin errors++; $display("FAIL flush_same_cycle ready_seen %b re %b rdata %h want 0 0 a5a50044", seen, bus.mmu_read_enable, bus.if_rdata); end
  endtask
  task automatic test_reset_mid;
    bit seen;
    mmu_off = 1'b1;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h500;
    tick;
    tick;
    checks++; if (!bus.mmu_read_enable) begin errors++; $display("FAIL rst_mid_busy re %b want 1", bus.mmu_read_enable); end
    reset = 1'b1;
    bus.d_req = 1'b0;
    tick;
    checks++; if (bus.mmu_read_enable || bus.mmu_write_enable || bus.mmu_address !== 32'h0 || bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h0 || bus.d_ready || bus.d_stall) begin errors++; $display("FAIL rst_mid_clear re %b we %b addr %h d_rdata %h if_rdata %h d_ready %b", bus.mmu_read_enable, bus.mmu_write_enable, bus.mmu_address, bus.d_rdata, bus.if_rdata, bus.d_ready); end
    reset = 1'b0;
    mmu_off = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      tick;
      if (bus.d_ready || bus.mmu_read_enable) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_no_pulse got activity %b want 0", seen); end
  endtask
  initial begin
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.if_flush = 1'b0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_signed = 1'b0;
    bus.d_width = '0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.mmu_mem_ready = 1'b0;
    bus.mmu_data_out = '0;
    test_reset;
    test_fetch;
    test_priority;
    test_streak;
    test_store;
    test_timeout;
    test_flush;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
